// File: rtl/core_csr_file.sv
// core_csr_file: Zicsr CSR file (cycle/time/instret/hpm counters, mcycle/minstret aliases, mscratch).
// Define CSR_COUNTINHIBIT_EN to add mcountinhibit at 0x320.
module core_csr_file #(
    parameter int XLEN         = 32,
    parameter int CNT_WIDTH    = 64,
    parameter int NUM_HPM      = 4,
    parameter int CSR_ADDR     = 12,
    parameter int CSR_OP_WIDTH = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [CSR_OP_WIDTH-1:0]                csr_op_i,
    input  logic [CSR_ADDR-1:0]                    csr_addr_i,
    input  logic [XLEN-1:0]                        csr_val_i,
    input  logic [4:0]                             csr_zimm_i,
    input  logic                                   csr_rs1_x0_i,
    input  logic                                   retire_i,
    input  logic                                   time_tick_i,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
    output logic [XLEN-1:0]                        csr_val_o,
    output logic                                   csr_valid_o,
    output logic                                   csr_illegal_o
);
    // Counter index matches the low address bits: 0 cycle, 1 time, 2 instret, 3+k hpm k.
    localparam int NC = 3 + NUM_HPM;
    localparam logic [CSR_OP_WIDTH-1:0] OP_RW  = CSR_OP_WIDTH'(1);
    localparam logic [CSR_OP_WIDTH-1:0] OP_RS  = CSR_OP_WIDTH'(2);
    localparam logic [CSR_OP_WIDTH-1:0] OP_RC  = CSR_OP_WIDTH'(3);
    localparam logic [CSR_OP_WIDTH-1:0] OP_RWI = CSR_OP_WIDTH'(4);
    localparam logic [CSR_OP_WIDTH-1:0] OP_RSI = CSR_OP_WIDTH'(5);
    localparam logic [CSR_OP_WIDTH-1:0] OP_RCI = CSR_OP_WIDTH'(6);
    localparam logic [CSR_OP_WIDTH-1:0] OP_ILL = CSR_OP_WIDTH'(7);
    localparam logic [CSR_ADDR-1:0]     A_SCR  = CSR_ADDR'(12'h340);

    logic [CNT_WIDTH-1:0] ctr [NC];
    logic [XLEN-1:0]      mscratch, src, rd, nv;
    logic [NC-1:0]        inc, wlo, whi;
    logic [4:0]           idx;
    logic                 is_imm, rw, rs, rc, wr_int, cnt_sel, ro, mapped, illegal, req, do_wr;

`ifdef CSR_COUNTINHIBIT_EN
    localparam logic [CSR_ADDR-1:0] A_INH    = CSR_ADDR'(12'h320);
    localparam logic [XLEN-1:0]     INH_MASK = ((XLEN'(1) << NC) - XLEN'(1)) & ~XLEN'(2);
    logic [XLEN-1:0] inh;
`endif

    assign idx = csr_addr_i[4:0];
    assign req = csr_op_i != '0;

    always_comb begin
        rw      = csr_op_i == OP_RW || csr_op_i == OP_RWI;
        rs      = csr_op_i == OP_RS || csr_op_i == OP_RSI;
        rc      = csr_op_i == OP_RC || csr_op_i == OP_RCI;
        is_imm  = csr_op_i == OP_RWI || csr_op_i == OP_RSI || csr_op_i == OP_RCI;
        src     = is_imm ? XLEN'(csr_zimm_i) : csr_val_i;
        wr_int  = rw || ((rs || rc) && (is_imm ? csr_zimm_i != 5'd0 : !csr_rs1_x0_i));
        ro      = csr_addr_i[11:8] == 4'hC;
        // 0xB01 would alias time, which has no writable form.
        cnt_sel = (ro || csr_addr_i[11:8] == 4'hB) && csr_addr_i[6:5] == 2'b00 &&
                  {27'b0, idx} < NC && !(!ro && idx == 5'd1);
        rd      = '0;
        mapped  = cnt_sel;
        for (int i = 0; i < NC; i++)
            if (cnt_sel && idx == 5'(i)) rd = csr_addr_i[7] ? ctr[i][CNT_WIDTH-1:XLEN] : ctr[i][XLEN-1:0];
        if (csr_addr_i == A_SCR) begin
            rd     = mscratch;
            mapped = 1'b1;
        end
`ifdef CSR_COUNTINHIBIT_EN
        if (csr_addr_i == A_INH) begin
            rd     = inh;
            mapped = 1'b1;
        end
`endif
        illegal = csr_op_i == OP_ILL || !mapped || (ro && wr_int);
        nv      = rw ? src : rs ? rd | src : rd & ~src;
        do_wr   = req && !illegal && wr_int;
        wlo     = '0;
        whi     = '0;
        for (int i = 0; i < NC; i++) begin
            wlo[i] = do_wr && cnt_sel && idx == 5'(i) && !csr_addr_i[7];
            whi[i] = do_wr && cnt_sel && idx == 5'(i) && csr_addr_i[7];
        end
        inc    = '0;
        inc[0] = 1'b1;
        inc[1] = time_tick_i;
        inc[2] = retire_i;
        for (int k = 0; k < NUM_HPM; k++) inc[3+k] = hpm_event_i[k];
`ifdef CSR_COUNTINHIBIT_EN
        inc = inc & ~inh[NC-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NC; i++) ctr[i] <= '0;
            mscratch      <= '0;
            csr_val_o     <= '0;
            csr_valid_o   <= 1'b0;
            csr_illegal_o <= 1'b0;
        end else begin
            // A write to either half suppresses that counter's increment for the cycle.
            for (int i = 0; i < NC; i++)
                if (wlo[i]) ctr[i][XLEN-1:0] <= nv;
                else if (whi[i]) ctr[i][CNT_WIDTH-1:XLEN] <= nv;
                else if (inc[i]) ctr[i] <= ctr[i] + CNT_WIDTH'(1);
            if (do_wr && csr_addr_i == A_SCR) mscratch <= nv;
            csr_valid_o   <= req;
            csr_illegal_o <= req && illegal;
            if (req) csr_val_o <= illegal ? '0 : rd;
        end
    end

`ifdef CSR_COUNTINHIBIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inh <= '0;
        else if (do_wr && csr_addr_i == A_INH) inh <= nv & INH_MASK;
    end
`endif
endmodule
